branch_predictor_2bit: RTL and testbench
========================================

# branch_predictor_2bit

Dynamic branch predictor for the in-order RISC-V pipeline: a small table of 2-bit saturating counters indexed by branch PC. It computes the branch target and a taken/not-taken prediction at decode, and trains the counter when the branch resolves in the memory stage. Target arithmetic and prediction are combinational; the counter table is the only state.

## Interface
Parameters:
- INDEX_BITS, 2: log2 of counter-table entries (4 entries by default).
- UPDATE_LAT, 2: cycles between a branch's decode and its resolution at the memory stage.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- branch_decode_sig  input  1  a conditional branch is in decode this cycle.
- branch_mem_sig  input  1  a conditional branch resolves in the memory stage this cycle.
- actual_branch_decision  input  1  resolved outcome, 1 = taken; valid when branch_mem_sig = 1.
- in_addr  input  32  PC of the branch in decode.
- offset  input  32  sign-extended branch immediate.
- branch_addr  output  32  predicted target, in_addr + offset.
- prediction  output  1  1 = predict taken.
- check0  output  2  current counter value of table entry 0 (debug).

## Operation
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup index: in_addr[INDEX_BITS+1:2], since the 2 LSBs are ignored for word alignment.
- prediction = branch_decode_sig & table[lookup_index][1]. It is 0 whenever branch_decode_sig = 0.
- branch_addr = in_addr + offset, modulo 2^32. There is no overflow flag and wrap-around is silent. It is driven regardless of branch_decode_sig.
- Index pipeline: a UPDATE_LAT-deep shift register of {valid, index} advances every clock. Each stage loads {branch_decode_sig, lookup_index}. The update index is the tail entry. When UPDATE_LAT = 0, the lookup index is used directly.
- Training happens on a rising edge with branch_mem_sig = 1:
  - Taken: the counter increments, saturating at 11.
  - Not taken: the counter decrements, saturating at 00.
- The update is applied even if the tail valid bit is 0, so branch_mem_sig is authoritative.
- The untouched entries hold their values.
- check0 = table[0], registered value.

## Timing
- Reset (rst_n = 0, asynchronous): every counter is 01 and the index pipeline is cleared to index 0, invalid. Resulting outputs: prediction = 0, check0 = 01, branch_addr = in_addr + offset, which is still live.
- Release of rst_n takes effect at the next rising edge; no update occurs on the edge where rst_n is low.
- The counter update is visible on prediction and check0 one cycle after the training edge.
- Simultaneous lookup and update of the same entry: prediction uses the pre-update counter. There is no bypass.
- Reset asserted mid-operation aborts pending updates immediately.
- prediction and branch_addr have zero latency and are purely combinational.

## Structure
- Shared package:
  - Counter state constants SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - Reset counter value WNT.
  - XLEN = 32.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down counter with async active-low reset, enable and direction inputs. It is instantiated once per table entry.
- The index shift register and the adder stay in the top level.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with no clock edge. Required: check0 = 01 and prediction = 0 immediately, with branch_decode_sig = 1.
- Target adder:
  - in_addr = 0x84, offset = 0 gives branch_addr = 0x84.
  - offset = 0xFFFFFFFC gives 0x80.
  - in_addr = 0xFFFFFFFC, offset = 8 gives 0x00000004 (wrap).
- Training sequence: in_addr = 0x84 fixed (index 1), then repeat with in_addr = 0x80 (index 0); branch_decode_sig = branch_mem_sig = 1, UPDATE_LAT = 0. Outcomes T, N, T, N, T, T, N, T, T on successive edges. Required counter after each edge: 10, 01, 10, 01, 10, 11, 10, 11, 11. For index 0, check0 follows this sequence and prediction = bit 1 of the counter one cycle later.
- Saturation: five not-taken updates from reset hold at 00, and five taken updates hold at 11. There is no wrap.
- Gating: the counter is at 11 with branch_decode_sig = 0, so prediction = 0. With branch_mem_sig = 0 and actual_branch_decision toggling, the counters do not change.
- Latency and aliasing, with UPDATE_LAT = 2:
  - Decode a branch at 0x80 on cycle 0 and assert branch_mem_sig with taken on cycle 2. Required: only entry 0 moves 01 to 10, while in_addr = 0x84 is in decode during the update.
  - Address 0x90 aliases to entry 0 and predicts from the same counter.

Source files
------------

// File: rtl/branch_predictor_2bit_pkg.sv
// Shared definitions for the 2-bit saturating-counter branch predictor.
//   XLEN       - datapath width of PCs and branch offsets
//   ctr_t      - 2-bit counter type and its four named states
//   sat_next() - next counter value for one training step
package branch_predictor_2bit_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strong not-taken
    localparam ctr_t WNT = 2'b01;  // weak not-taken
    localparam ctr_t WT  = 2'b10;  // weak taken
    localparam ctr_t ST  = 2'b11;  // strong taken

    localparam ctr_t CTR_RESET = WNT;

    // One saturating step toward taken (up = 1) or not-taken (up = 0).
    function automatic ctr_t sat_next(input ctr_t cur, input logic up);
        ctr_t nxt;
        nxt = cur;
        if (up) begin
            if (cur != ST) nxt = cur + 2'b01;
        end else begin
            if (cur != SNT) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per predictor table entry.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, loads CTR_RESET (weak not-taken)
//   en     - apply one training step on this edge
//   up     - step direction, 1 = toward taken
//   cnt    - current registered counter value
module sat_counter2
    import branch_predictor_2bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output logic [1:0] cnt
);

    ctr_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = sat_next(cnt_q, up);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CTR_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor_2bit.sv
// Dynamic branch predictor: a table of 2-bit saturating counters indexed by
// branch PC bits [INDEX_BITS+1:2]. Predicts at decode, trains at memory stage.
//   clk, rst_n             - clock, asynchronous active-low reset
//   branch_decode_sig      - conditional branch in decode this cycle
//   branch_mem_sig         - conditional branch resolves this cycle (trains)
//   actual_branch_decision - resolved outcome, 1 = taken
//   in_addr, offset        - decode PC and sign-extended immediate
//   branch_addr            - in_addr + offset (combinational, wraps silently)
//   prediction             - 1 = predict taken (combinational, gated by decode)
//   check0                 - registered counter of table entry 0 (debug)
module branch_predictor_2bit
    import branch_predictor_2bit_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned UPDATE_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_decode_sig,
    input  logic            branch_mem_sig,
    input  logic            actual_branch_decision,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] branch_addr,
    output logic            prediction,
    output logic [1:0]      check0
);

    localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    ctr_t                  cnt [NUM_ENTRIES];

    // Word-aligned PCs: the two LSBs carry no information.
    assign lookup_idx = in_addr[INDEX_BITS+1:2];

    // Index pipeline from decode to memory stage. Only the index is carried:
    // branch_mem_sig alone decides whether an update happens, so a stage
    // valid flag would never influence the table.
    generate
        if (UPDATE_LAT == 0) begin : g_no_pipe
            assign upd_idx = lookup_idx;
        end else begin : g_pipe
            logic [INDEX_BITS-1:0] idx_q [UPDATE_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(UPDATE_LAT); i++) idx_q[i] <= '0;
                end else begin
                    idx_q[0] <= lookup_idx;
                    for (int i = 1; i < int'(UPDATE_LAT); i++) idx_q[i] <= idx_q[i-1];
                end
            end

            assign upd_idx = idx_q[UPDATE_LAT-1];
        end
    endgenerate

    generate
        for (genvar i = 0; i < int'(NUM_ENTRIES); i++) begin : g_entry
            sat_counter2 u_ctr (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (branch_mem_sig && (upd_idx == INDEX_BITS'(i))),
                .up    (actual_branch_decision),
                .cnt   (cnt[i])
            );
        end
    endgenerate

    // Lookup reads registered counters, so a same-cycle update to the same
    // entry is not bypassed.
    assign prediction  = branch_decode_sig & cnt[lookup_idx][1];
    assign branch_addr = in_addr + offset;
    assign check0      = cnt[0];

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Directed bench for branch_predictor_2bit. Two instances share stimulus:
// u_dut0 (UPDATE_LAT = 0) for training/saturation/gating, u_dut2
// (UPDATE_LAT = 2) for update latency and aliasing.
module tb_branch_predictor_2bit;

    logic        clk;
    logic        rst_n;
    logic        branch_decode_sig;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [31:0] in_addr;
    logic [31:0] offset;

    logic [31:0] branch_addr0, branch_addr2;
    logic        prediction0, prediction2;
    logic [1:0]  check0_0, check0_2;

    int vectors     = 0;
    int miscompares = 0;

    branch_predictor_2bit #(
        .INDEX_BITS (2),
        .UPDATE_LAT (0)
    ) u_dut0 (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .branch_decode_sig      (branch_decode_sig),
        .branch_mem_sig         (branch_mem_sig),
        .actual_branch_decision (actual_branch_decision),
        .in_addr                (in_addr),
        .offset                 (offset),
        .branch_addr            (branch_addr0),
        .prediction             (prediction0),
        .check0                 (check0_0)
    );

    branch_predictor_2bit #(
        .INDEX_BITS (2),
        .UPDATE_LAT (2)
    ) u_dut2 (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .branch_decode_sig      (branch_decode_sig),
        .branch_mem_sig         (branch_mem_sig),
        .actual_branch_decision (actual_branch_decision),
        .in_addr                (in_addr),
        .offset                 (offset),
        .branch_addr            (branch_addr2),
        .prediction             (prediction2),
        .check0                 (check0_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One UPDATE_LAT=0 training edge; checks the counter through prediction,
    // and through check0 (trained entry 0) or its untouched value (entry 1).
    task automatic train(input logic taken, input logic [1:0] exp, input bit on_idx0,
                         input int step);
        actual_branch_decision = taken;
        @(posedge clk);
        #1;
        chk($sformatf("train%0d_idx%0d_pred", step, on_idx0 ? 0 : 1),
            {31'd0, prediction0}, {31'd0, exp[1]});
        if (on_idx0) chk($sformatf("train%0d_check0", step), {30'd0, check0_0}, {30'd0, exp});
        else         chk($sformatf("train%0d_entry0_hold", step), {30'd0, check0_0}, 32'd1);
    endtask

    logic       outcomes [9];
    logic [1:0] exp_seq  [9];

    initial begin
        outcomes = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_seq  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};

        rst_n = 1'b1;
        branch_decode_sig = 1'b0;
        branch_mem_sig = 1'b0;
        actual_branch_decision = 1'b0;
        in_addr = 32'h0;
        offset = 32'h0;

        // Asynchronous reset with the clock low: takes effect without an edge.
        #2;
        branch_decode_sig = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_check0", {30'd0, check0_0}, 32'd1);
        chk("rst_pred", {31'd0, prediction0}, 32'd0);
        chk("rst_check0_lat2", {30'd0, check0_2}, 32'd1);

        // Target adder is live during reset.
        in_addr = 32'h84; offset = 32'h0; #1;
        chk("add_zero", branch_addr0, 32'h84);
        offset = 32'hFFFF_FFFC; #1;
        chk("add_neg", branch_addr0, 32'h80);
        in_addr = 32'hFFFF_FFFC; offset = 32'h8; #1;
        chk("add_wrap", branch_addr0, 32'h4);

        @(negedge clk);
        rst_n = 1'b1;
        in_addr = 32'h84;
        offset = 32'h0;
        branch_decode_sig = 1'b1;
        branch_mem_sig = 1'b1;

        for (int k = 0; k < 9; k++) train(outcomes[k], exp_seq[k], 1'b0, k);
        in_addr = 32'h80;
        for (int k = 0; k < 9; k++) train(outcomes[k], exp_seq[k], 1'b1, k);

        // Saturation from reset.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            actual_branch_decision = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("sat_nt%0d", k), {30'd0, check0_0}, 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            actual_branch_decision = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("sat_t%0d", k), {30'd0, check0_0}, (k >= 2) ? 32'd3 : 32'(k + 1));
        end

        // Gating: no decode -> no prediction; no mem strobe -> no training.
        branch_decode_sig = 1'b0; #1;
        chk("gate_pred", {31'd0, prediction0}, 32'd0);
        branch_mem_sig = 1'b0;
        for (int k = 0; k < 3; k++) begin
            actual_branch_decision = ~actual_branch_decision;
            @(posedge clk); #1;
            chk($sformatf("gate_hold%0d", k), {30'd0, check0_0}, 32'd3);
        end
        branch_decode_sig = 1'b1; #1;
        chk("gate_pred_on", {31'd0, prediction0}, 32'd1);

        // UPDATE_LAT = 2: decode 0x80 on cycle 0, resolve taken on cycle 2.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        branch_mem_sig = 1'b0;
        branch_decode_sig = 1'b1;
        in_addr = 32'h80;
        @(posedge clk); #1;
        branch_decode_sig = 1'b0;
        in_addr = 32'h84;
        @(posedge clk); #1;
        branch_decode_sig = 1'b1;
        branch_mem_sig = 1'b1;
        actual_branch_decision = 1'b1;
        chk("lat_pre_check0", {30'd0, check0_2}, 32'd1);
        @(posedge clk); #1;
        branch_mem_sig = 1'b0;
        chk("lat_post_check0", {30'd0, check0_2}, 32'd2);
        chk("lat_entry1_pred", {31'd0, prediction2}, 32'd0);
        in_addr = 32'h90; #1;
        chk("alias_0x90_pred", {31'd0, prediction2}, 32'd1);
        in_addr = 32'h80; #1;
        chk("alias_0x80_pred", {31'd0, prediction2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
